// File: rtl/fabric_store_pair_pkg.sv
// Shared error codes, types and elaboration helpers for fabric_store_pair.
// Optional feature macro used by the top: FABRIC_STORE_PAIR_BYPASS_EN.
package fabric_store_pair_pkg;

  typedef logic [15:0] err_code_t;

  // RT_MEMORY_STORE_DEADLOCK is the established fabric code; the mismatch code takes the next slot.
  localparam err_code_t RT_MEMORY_STORE_DEADLOCK     = 16'h0021;
  localparam err_code_t RT_MEMORY_STORE_TAG_MISMATCH = 16'h0022;

  localparam int unsigned WAIT_W = 16;

  function automatic logic is_pow2_ge2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fabric_store_pair_fifo.sv
// Small power-of-two FIFO with registered head; a push becomes visible at the head one cycle later.
module fabric_store_pair_fifo
  import fabric_store_pair_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  input  logic             pop_i
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  generate
    if (!is_pow2_ge2(DEPTH)) begin : g_bad_depth
      $fatal(1, "fabric_store_pair_fifo: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_fire, pop_fire;

  // Readiness depends only on the stored count, so a pop never frees a slot in the same cycle.
  assign push_ready_o = (count_q < FULL_COUNT);
  assign empty_o      = (count_q == '0);
  assign head_o       = mem_q[rd_ptr_q];
  assign push_fire    = push_valid_i && push_ready_o;
  assign pop_fire     = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_fire) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_fire)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW + 1)'(push_fire) - (PW + 1)'(pop_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fabric_store_pair.sv
// Pairs independent store-address and store-data streams in arrival order for fabric_memory.
// Optional same-cycle pass-through when FABRIC_STORE_PAIR_BYPASS_EN is defined.
module fabric_store_pair
  import fabric_store_pair_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int TAG_WIDTH  = 0,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 65535,
  localparam int SAFE_TW   = (TAG_WIDTH > 0) ? TAG_WIDTH : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            addr_valid,
  output logic                            addr_ready,
  input  logic [ADDR_WIDTH+TAG_WIDTH-1:0] addr_data,
  input  logic                            data_valid,
  output logic                            data_ready,
  input  logic [DATA_WIDTH+TAG_WIDTH-1:0] data_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ADDR_WIDTH-1:0]           out_addr,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [SAFE_TW-1:0]              out_tag,
  output logic                            error_valid,
  output logic [15:0]                     error_code
);

  localparam int AFW = ADDR_WIDTH + TAG_WIDTH;
  localparam int DFW = DATA_WIDTH + TAG_WIDTH;
  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

  generate
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $fatal(1, "fabric_store_pair: TIMEOUT must be within 1..65535");
    end
  endgenerate

  logic [AFW-1:0]     a_head;
  logic [DFW-1:0]     d_head;
  logic               a_empty, d_empty;
  logic               a_push_valid, d_push_valid;
  logic               pop;
  logic [SAFE_TW-1:0] a_tag, d_tag;
  logic               both_present, tag_eq, fifo_pair, mismatch;
  logic               waiting, deadlock;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               err_valid_q, err_valid_d;
  err_code_t          err_code_q, err_code_d;

  fabric_store_pair_fifo #(.WIDTH(AFW), .DEPTH(DEPTH)) u_addr_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (a_push_valid),
    .push_ready_o (addr_ready),
    .push_data_i  (addr_data),
    .head_o       (a_head),
    .empty_o      (a_empty),
    .pop_i        (pop)
  );

  fabric_store_pair_fifo #(.WIDTH(DFW), .DEPTH(DEPTH)) u_data_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (d_push_valid),
    .push_ready_o (data_ready),
    .push_data_i  (data_data),
    .head_o       (d_head),
    .empty_o      (d_empty),
    .pop_i        (pop)
  );

  generate
    if (TAG_WIDTH > 0) begin : g_tagged
      assign a_tag = a_head[AFW-1 -: SAFE_TW];
      assign d_tag = d_head[DFW-1 -: SAFE_TW];
    end else begin : g_untagged
      assign a_tag = '0;
      assign d_tag = '0;
    end
  endgenerate

  assign both_present = !a_empty && !d_empty;
  assign tag_eq       = (a_tag == d_tag);
  assign fifo_pair    = both_present && tag_eq;
  assign mismatch     = both_present && !tag_eq;
  assign pop          = fifo_pair && out_ready;

`ifdef FABRIC_STORE_PAIR_BYPASS_EN
  logic [SAFE_TW-1:0] in_a_tag, in_d_tag;
  logic               bypass;

  generate
    if (TAG_WIDTH > 0) begin : g_in_tagged
      assign in_a_tag = addr_data[AFW-1 -: SAFE_TW];
      assign in_d_tag = data_data[DFW-1 -: SAFE_TW];
    end else begin : g_in_untagged
      assign in_a_tag = '0;
      assign in_d_tag = '0;
    end
  endgenerate

  // Pass-through only from an empty pair of FIFOs; if not accepted, both beats queue normally.
  assign bypass       = a_empty && d_empty && addr_valid && data_valid && (in_a_tag == in_d_tag);
  assign out_valid    = fifo_pair || bypass;
  assign out_addr     = bypass ? addr_data[ADDR_WIDTH-1:0] : a_head[ADDR_WIDTH-1:0];
  assign out_data     = bypass ? data_data[DATA_WIDTH-1:0] : d_head[DATA_WIDTH-1:0];
  assign out_tag      = bypass ? in_a_tag : a_tag;
  assign a_push_valid = addr_valid && !(bypass && out_ready);
  assign d_push_valid = data_valid && !(bypass && out_ready);
`else
  assign out_valid    = fifo_pair;
  assign out_addr     = a_head[ADDR_WIDTH-1:0];
  assign out_data     = d_head[DATA_WIDTH-1:0];
  assign out_tag      = a_tag;
  assign a_push_valid = addr_valid;
  assign d_push_valid = data_valid;
`endif

  assign waiting  = a_empty ^ d_empty;
  assign deadlock = (wait_q == TIMEOUT_C);

  always_comb begin
    wait_d = '0;
    if (waiting) begin
      wait_d = deadlock ? wait_q : wait_q + WAIT_W'(1);
    end
  end

  // First error wins and is held; a mismatch outranks a simultaneous deadlock.
  always_comb begin
    err_valid_d = err_valid_q;
    err_code_d  = err_code_q;
    if (!err_valid_q && (mismatch || deadlock)) begin
      err_valid_d = 1'b1;
      err_code_d  = mismatch ? RT_MEMORY_STORE_TAG_MISMATCH : RT_MEMORY_STORE_DEADLOCK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q      <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      wait_q      <= wait_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign error_valid = err_valid_q;
  assign error_code  = err_code_q;

endmodule

// File: tb/tb_fabric_store_pair.sv
// Self-checking bench for fabric_store_pair: queue-based pairing model, directed scenarios, random traffic.
module tb_fabric_store_pair;
  import fabric_store_pair_pkg::*;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int TW = 2;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          addr_valid = 1'b0;
  logic          addr_ready;
  logic [AW+TW-1:0] addr_data = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic [DW+TW-1:0] data_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic          error_valid;
  logic [15:0]   error_code;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [AW+TW-1:0] aq[$];
  logic [DW+TW-1:0] dq[$];
  int               m_wait = 0;
  bit               m_err = 1'b0;
  logic [15:0]      m_code = '0;

  always #5 clk = ~clk;

  fabric_store_pair #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_data(addr_data),
    .data_valid(data_valid), .data_ready(data_ready), .data_data(data_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_tag(out_tag),
    .error_valid(error_valid), .error_code(error_code)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input bit av, input logic [AW+TW-1:0] ad, input bit dv,
                       input logic [DW+TW-1:0] dd, input bit ordy);
    addr_valid = av; addr_data = ad; data_valid = dv; data_data = dd; out_ready = ordy;
  endtask

  task automatic model_clear();
    aq.delete(); dq.delete();
    m_wait = 0; m_err = 1'b0; m_code = '0;
  endtask

  // Called at a falling edge with inputs set; compares, advances the model, returns at next falling edge.
  task automatic step(output bit afire, output bit dfire);
    bit a_ne, d_ne, both, teq, e_ov, byp, e_ar, e_dr;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    logic [TW-1:0] e_t;
    #1;
    a_ne = (aq.size() != 0);
    d_ne = (dq.size() != 0);
    both = a_ne && d_ne;
    teq = 1'b0; e_a = '0; e_d = '0; e_t = '0;
    if (both) begin
      teq = (aq[0][AW+TW-1:AW] == dq[0][DW+TW-1:DW]);
      e_a = aq[0][AW-1:0];
      e_d = dq[0][DW-1:0];
      e_t = aq[0][AW+TW-1:AW];
    end
    e_ov = both && teq;
    byp = 1'b0;
`ifdef FABRIC_STORE_PAIR_BYPASS_EN
    if (!a_ne && !d_ne && addr_valid && data_valid &&
        addr_data[AW+TW-1:AW] == data_data[DW+TW-1:DW]) begin
      byp = 1'b1; e_ov = 1'b1;
      e_a = addr_data[AW-1:0]; e_d = data_data[DW-1:0]; e_t = addr_data[AW+TW-1:AW];
    end
`endif
    e_ar = (aq.size() < DEPTH);
    e_dr = (dq.size() < DEPTH);
    chk("out_valid", out_valid, e_ov);
    if (e_ov) begin
      chk("out_addr", out_addr, e_a);
      chk("out_data", out_data, e_d);
      chk("out_tag", out_tag, e_t);
    end
    chk("addr_ready", addr_ready, e_ar);
    chk("data_ready", data_ready, e_dr);
    chk("error_valid", error_valid, m_err);
    chk("error_code", error_code, m_code);

    afire = addr_valid && e_ar;
    dfire = data_valid && e_dr;
    if (!m_err && ((both && !teq) || m_wait == TIMEOUT)) begin
      m_err = 1'b1;
      m_code = (both && !teq) ? RT_MEMORY_STORE_TAG_MISMATCH : RT_MEMORY_STORE_DEADLOCK;
    end
    m_wait = (a_ne != d_ne) ? ((m_wait == TIMEOUT) ? TIMEOUT : m_wait + 1) : 0;
    if (e_ov && out_ready && !byp) begin
      void'(aq.pop_front());
      void'(dq.pop_front());
    end
    if (!(byp && out_ready)) begin
      if (afire) aq.push_back(addr_data);
      if (dfire) dq.push_back(data_data);
    end
    @(negedge clk);
  endtask

  task automatic tick();
    bit af, df;
    step(af, df);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, '0, 0, '0, 0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_phase(input int n, input int pa, input int pd, input int pr);
    int na, nd;
    bit af, df;
    na = 0; nd = 0;
    for (int i = 0; i < n; i++) begin
      drive($urandom_range(0, 99) < pa, {na[TW-1:0], 6'($urandom)},
            $urandom_range(0, 99) < pd, {nd[TW-1:0], 8'($urandom)},
            $urandom_range(0, 99) < pr);
      step(af, df);
      if (af) na++;
      if (df) nd++;
    end
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    #1;
    chk("rst_addr_ready", addr_ready, 1);
    chk("rst_data_ready", data_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_error", {error_valid, error_code}, 0);

    // Burst: two addresses, then two data beats
    drive(1, {2'd0, 6'h05}, 0, '0, 1); tick();
    drive(1, {2'd1, 6'h06}, 0, '0, 1); tick();
    drive(0, '0, 1, {2'd0, 8'h0A}, 1); tick();
    drive(0, '0, 1, {2'd1, 8'h0B}, 1);
    #1;
    chk("burst_p0", {out_valid, out_addr, out_data}, {1'b1, 6'h05, 8'h0A});
    tick();
    drive(0, '0, 0, '0, 1);
    #1;
    chk("burst_p1", {out_valid, out_addr, out_data}, {1'b1, 6'h06, 8'h0B});
    tick();
    #1;
    chk("burst_empty", out_valid, 0);
    tick();

    // Back-pressure: fill both FIFOs, then drain
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, {2'(i), 6'(6'h20 + i)}, 1, {2'(i), 8'(8'h40 + i)}, 0);
      tick();
    end
    drive(1, {2'd0, 6'h3F}, 1, {2'd0, 8'hFF}, 1);
    #1;
    chk("bp_full_ready", {addr_ready, data_ready}, 2'b00);
    chk("bp_hold", {out_valid, out_addr, out_data, out_tag}, {1'b1, 6'h20, 8'h40, 2'd0});
    tick();
    drive(0, '0, 0, '0, 1);
    #1;
    chk("bp_second", {out_valid, out_addr, out_data}, {1'b1, 6'h21, 8'h41});
    repeat (5) tick();

    // Deadlock: lone address, error appears after TIMEOUT waiting cycles plus one
    do_reset();
    drive(1, {2'd0, 6'h01}, 0, '0, 1); tick();
    drive(0, '0, 0, '0, 1);
    repeat (9) tick();
    #1;
    chk("dl_error", {error_valid, error_code}, {1'b1, RT_MEMORY_STORE_DEADLOCK});
    drive(0, '0, 1, {2'd0, 8'h77}, 1); tick();
    drive(0, '0, 0, '0, 1);
    #1;
    chk("dl_pair_sticky", {out_valid, out_addr, out_data, error_valid}, {1'b1, 6'h01, 8'h77, 1'b1});
    repeat (2) tick();

    // Tag mismatch: heads retained, error raised
    do_reset();
    drive(1, {2'd1, 6'h03}, 1, {2'd2, 8'h55}, 1); tick();
    drive(0, '0, 0, '0, 1);
    #1;
    chk("tm_no_valid", {out_valid, out_addr, out_tag}, {1'b0, 6'h03, 2'd1});
    tick();
    #1;
    chk("tm_error", {error_valid, error_code}, {1'b1, RT_MEMORY_STORE_TAG_MISMATCH});
    tick();
    #1;
    chk("tm_held", {out_valid, out_addr, out_data}, {1'b0, 6'h03, 8'h55});

    // Reset mid-burst with queued addresses and an error latched
    for (int i = 0; i < 3; i++) begin
      drive(1, {2'd1, 6'(6'h30 + i)}, 0, '0, 1);
      tick();
    end
    drive(0, '0, 0, '0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {out_valid, addr_ready, error_valid, error_code}, {1'b0, 1'b1, 1'b0, 16'h0000});
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, '0, 1, {2'd1, 8'h66}, 1); tick();
    drive(0, '0, 0, '0, 1);
    #1;
    chk("no_stale_pair", out_valid, 0);
    repeat (2) tick();

`ifdef FABRIC_STORE_PAIR_BYPASS_EN
    do_reset();
    drive(1, {2'd0, 6'h10}, 1, {2'd0, 8'h99}, 1);
    #1;
    chk("byp_same_cycle", {out_valid, out_addr, out_data}, {1'b1, 6'h10, 8'h99});
    tick();
    drive(0, '0, 0, '0, 1);
    #1;
    chk("byp_fifos_empty", {out_valid, addr_ready, data_ready}, {1'b0, 1'b1, 1'b1});
    tick();
`endif

    // Random traffic with arrival-ordered tags
    do_reset();
    random_phase(300, 70, 70, 70);
    do_reset();
    random_phase(300, 35, 80, 50);
    do_reset();
    random_phase(200, 90, 90, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
